// File: rtl/slice_sched_pkg.sv
// slice_sched_pkg: FSM state and queued job record shared by the slice job scheduler.
package slice_sched_pkg;
    localparam int JOB_ROW_W = 3;
    localparam int JOB_COL_W = 3;

    typedef enum logic [2:0] {IDLE, CFG, START, WAIT, RESP} sched_st_t;

    typedef struct packed {
        logic                 id;
        logic                 mode;
        logic [JOB_ROW_W-1:0] row;
        logic [JOB_COL_W-1:0] col;
        logic [7:0]           len;
    } job_t;

    localparam int JOB_W = $bits(job_t);
endpackage

// File: rtl/slice_job_fifo.sv
// slice_job_fifo: DEPTH-entry job queue; pushes when full and pops when empty are dropped.
module slice_job_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= (wr == AW'(DEPTH - 1)) ? '0 : wr + 1'b1;
            if (do_pop) rd <= (rd == AW'(DEPTH - 1)) ? '0 : rd + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
endmodule

// File: rtl/slice_job_scheduler.sv
// slice_job_scheduler: round-robin queues row/col jobs from two requesters and issues them
// one at a time to the core, with a watchdog that completes stuck jobs with an error.
module slice_job_scheduler
    import slice_sched_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int ROW_W = M > 1 ? $clog2(M) : 1,
    parameter int COL_W = N > 1 ? $clog2(N) : 1,
    parameter int DEPTH = 4,
    parameter int TMO_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   r0_valid,
    output logic                   r0_ready,
    input  logic                   r0_mode,
    input  logic [ROW_W-1:0]       r0_row,
    input  logic [COL_W-1:0]       r0_col,
    input  logic [7:0]             r0_len,
    input  logic                   r1_valid,
    output logic                   r1_ready,
    input  logic                   r1_mode,
    input  logic [ROW_W-1:0]       r1_row,
    input  logic [COL_W-1:0]       r1_col,
    input  logic [7:0]             r1_len,
    output logic                   core_cfg_we,
    output logic                   core_mode_rowcol,
    output logic [ROW_W-1:0]       core_row_idx,
    output logic [COL_W-1:0]       core_col_idx,
    output logic [7:0]             core_len_cfg,
    output logic                   core_start,
    input  logic                   core_busy,
    input  logic                   core_done,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   sched_busy
);
    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W - 1){1'b1}}, 1'b0};

    sched_st_t        state;
    job_t             din, head, job;
    logic             full, empty, gnt, last_gnt, push, pop;
    logic [TMO_W-1:0] wd;

    assign gnt      = (r0_valid && r1_valid) ? !last_gnt : r1_valid;
    assign r0_ready = !rst && !full && r0_valid && !gnt;
    assign r1_ready = !rst && !full && r1_valid && gnt;
    assign push     = r0_ready || r1_ready;
    assign pop      = state == IDLE && !empty;

    always_comb begin
        din.id   = gnt;
        din.mode = gnt ? r1_mode : r0_mode;
        din.row  = JOB_ROW_W'(gnt ? r1_row : r0_row);
        din.col  = JOB_COL_W'(gnt ? r1_col : r0_col);
        din.len  = gnt ? r1_len : r0_len;
    end

    slice_job_fifo #(.DEPTH(DEPTH), .W(JOB_W)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (din),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(q_count)
    );

    assign core_mode_rowcol = job.mode;
    assign core_row_idx     = ROW_W'(job.row);
    assign core_col_idx     = COL_W'(job.col);
    assign core_len_cfg     = job.len;
    assign sched_busy       = state != IDLE;

    // core_start is registered from core_busy sampled one cycle earlier, so a dropping
    // busy yields a start on the very next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            job         <= '0;
            wd          <= '0;
            core_cfg_we <= 1'b0;
            core_start  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            if (push) last_gnt <= gnt;
            core_cfg_we <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_err     <= 1'b0;
            case (state)
                IDLE: if (!empty) begin
                    job         <= head;
                    core_cfg_we <= 1'b1;
                    state       <= CFG;
                end
                CFG: begin
                    core_start <= !core_busy;
                    state      <= START;
                end
                START: if (core_start) begin
                    core_start <= 1'b0;
                    wd         <= '0;
                    state      <= WAIT;
                end else begin
                    core_start <= !core_busy;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (core_done || wd == WD_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= job.id;
                        rsp_err   <= !core_done;
                        state     <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slice_job_scheduler.sv
// tb_slice_job_scheduler: directed scenarios plus randomized traffic checked every cycle
// against a queue-based model of the scheduling rules.
module tb_slice_job_scheduler;
    localparam int DEPTH = 4;
    localparam int TMAX  = 1 << 12;

    typedef struct {
        bit       id;
        bit       mode;
        bit [2:0] row;
        bit [2:0] col;
        bit [7:0] len;
    } mjob_t;

    logic       clk = 0, rst = 1;
    logic       r0_valid = 0, r0_mode = 0, r1_valid = 0, r1_mode = 0;
    logic [2:0] r0_row = 0, r0_col = 0, r1_row = 0, r1_col = 0;
    logic [7:0] r0_len = 0, r1_len = 0;
    logic       core_busy = 0, core_done = 0;

    logic       r0_ready, r1_ready, core_cfg_we, core_mode_rowcol, core_start;
    logic       rsp_valid, rsp_id, rsp_err, sched_busy;
    logic [2:0] core_row_idx, core_col_idx, q_count;
    logic [7:0] core_len_cfg;

    logic       t_r0_ready, t_r1_ready, t_core_cfg_we, t_core_mode_rowcol, t_core_start;
    logic       t_rsp_valid, t_rsp_id, t_rsp_err, t_sched_busy;
    logic [2:0] t_core_row_idx, t_core_col_idx, t_q_count;
    logic [7:0] t_core_len_cfg;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    slice_job_scheduler dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_mode(r0_mode), .r0_row(r0_row),
        .r0_col(r0_col), .r0_len(r0_len),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_mode(r1_mode), .r1_row(r1_row),
        .r1_col(r1_col), .r1_len(r1_len),
        .core_cfg_we(core_cfg_we), .core_mode_rowcol(core_mode_rowcol),
        .core_row_idx(core_row_idx), .core_col_idx(core_col_idx), .core_len_cfg(core_len_cfg),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .q_count(q_count), .sched_busy(sched_busy)
    );

    slice_job_scheduler #(.TMO_W(4)) dut_t (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(t_r0_ready), .r0_mode(r0_mode), .r0_row(r0_row),
        .r0_col(r0_col), .r0_len(r0_len),
        .r1_valid(r1_valid), .r1_ready(t_r1_ready), .r1_mode(r1_mode), .r1_row(r1_row),
        .r1_col(r1_col), .r1_len(r1_len),
        .core_cfg_we(t_core_cfg_we), .core_mode_rowcol(t_core_mode_rowcol),
        .core_row_idx(t_core_row_idx), .core_col_idx(t_core_col_idx),
        .core_len_cfg(t_core_len_cfg),
        .core_start(t_core_start), .core_busy(core_busy), .core_done(core_done),
        .rsp_valid(t_rsp_valid), .rsp_id(t_rsp_id), .rsp_err(t_rsp_err),
        .q_count(t_q_count), .sched_busy(t_sched_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Model: queued jobs, the job at the core, its phase (0 idle,1 cfg,2 start,3 wait,4 resp),
    // whether start is being asserted, cycles spent waiting, and who was granted last.
    mjob_t q[$];
    mjob_t cur = '{default: 0};
    int    phase = 0, waited = 0;
    bit    starting = 0, m_err = 0, last = 1, g0, g1;

    function automatic bit exp_r0();
        return !rst && q.size() < DEPTH && r0_valid && (!r1_valid || last);
    endfunction

    function automatic bit exp_r1();
        return !rst && q.size() < DEPTH && r1_valid && (!r0_valid || !last);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            cur      = '{default: 0};
            phase    = 0;
            waited   = 0;
            starting = 0;
            m_err    = 0;
            last     = 1;
        end else begin
            g0 = exp_r0();
            g1 = exp_r1();
            case (phase)
                0: if (q.size() > 0) begin cur = q.pop_front(); phase = 1; end
                1: begin starting = !core_busy; phase = 2; end
                2: if (starting) begin starting = 0; waited = 0; phase = 3; end
                   else starting = !core_busy;
                3: if (core_done) begin m_err = 0; phase = 4; end
                   else if (waited + 1 == TMAX - 1) begin m_err = 1; phase = 4; end
                   else waited++;
                default: phase = 0;
            endcase
            if (g0) begin q.push_back('{1'b0, r0_mode, r0_row, r0_col, r0_len}); last = 0; end
            else if (g1) begin q.push_back('{1'b1, r1_mode, r1_row, r1_col, r1_len}); last = 1; end
        end
    end

    logic [25:0] act_v, exp_v;
    bit on;
    always @(negedge clk) begin
        on = !rst;
        act_v = {r0_ready, r1_ready, core_cfg_we, core_start, rsp_valid, rsp_id, rsp_err,
                 core_mode_rowcol, core_row_idx, core_col_idx, core_len_cfg, q_count, sched_busy};
        exp_v = {exp_r0(), exp_r1(), on && phase == 1, on && phase == 2 && starting,
                 on && phase == 4, on && phase == 4 && cur.id, on && phase == 4 && m_err,
                 on && cur.mode, on ? cur.row : 3'd0, on ? cur.col : 3'd0,
                 on ? cur.len : 8'd0, on ? 3'(q.size()) : 3'd0, on && phase != 0};
        chk("outputs", 32'(act_v), 32'(exp_v));
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        r0_valid = 0; r1_valid = 0; core_busy = 0; core_done = 0;
        rst = 1;
        nxt();
        nxt();
        rst = 0;
    endtask

    int rsp_seen;

    initial begin
        // Single job on dut; same traffic times out on the 4-bit watchdog instance.
        do_reset();
        #1 chk("reset q_count", 32'(q_count), 0);
        nxt(); r0_valid = 1; r0_mode = 0; r0_row = 3'd3; r0_col = 3'd5; r0_len = 8'd0;
        #1 chk("c0 r0_ready", 32'(r0_ready), 1);
        nxt(); r0_valid = 0; r1_valid = 1; r1_mode = 1; r1_row = 3'd6; r1_col = 3'd2; r1_len = 8'd9;
        nxt(); r1_valid = 0;
        #1 chk("c2 cfg_we", 32'(core_cfg_we), 1);
        chk("c2 row_idx", 32'(core_row_idx), 3);
        nxt();
        #1 chk("c3 core_start", 32'(core_start), 1);
        repeat (16) nxt();
        #1 chk("c19 tmo rsp_valid", 32'(t_rsp_valid), 1);
        chk("c19 tmo rsp_err", 32'(t_rsp_err), 1);
        chk("c19 tmo rsp_id", 32'(t_rsp_id), 0);
        chk("c19 rsp_valid", 32'(rsp_valid), 0);
        nxt(); core_done = 1;
        nxt(); core_done = 0;
        #1 chk("c21 rsp_valid", 32'(rsp_valid), 1);
        chk("c21 rsp_id", 32'(rsp_id), 0);
        chk("c21 rsp_err", 32'(rsp_err), 0);
        chk("c21 tmo next cfg_we", 32'(t_core_cfg_we), 1);
        chk("c21 tmo next row", 32'(t_core_row_idx), 6);
        nxt();
        #1 chk("c22 tmo next start", 32'(t_core_start), 1);

        // Contention while a job sits at the core, then full-with-pop and busy hold.
        do_reset();
        nxt(); r1_valid = 1; r1_row = 3'd1;
        nxt(); r1_valid = 0;
        repeat (3) nxt();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            r0_valid = 1; r1_valid = 1; r0_row = 3'(i); r1_row = 3'(i + 4);
            #1 chk("grant r0", 32'(r0_ready), 32'(i % 2 == 0));
            chk("grant r1", 32'(r1_ready), 32'(i % 2 == 1));
        end
        nxt();
        #1 chk("full q_count", 32'(q_count), 4);
        chk("full r0_ready", 32'(r0_ready), 0);
        chk("full r1_ready", 32'(r1_ready), 0);
        chk("model depth", 32'(q.size()), 4);
        r1_valid = 0; core_done = 1;
        nxt(); core_done = 0;
        nxt();
        #1 chk("full pop r0_ready", 32'(r0_ready), 0);
        chk("full pop q_count", 32'(q_count), 4);
        nxt(); core_busy = 1;
        #1 chk("after pop q_count", 32'(q_count), 3);
        chk("after pop r0_ready", 32'(r0_ready), 1);
        nxt(); r0_valid = 0;
        #1 chk("refill q_count", 32'(q_count), 4);
        chk("busy start a", 32'(core_start), 0);
        nxt();
        #1 chk("busy start b", 32'(core_start), 0);
        nxt(); core_busy = 0;
        #1 chk("busy start c", 32'(core_start), 0);
        nxt();
        #1 chk("busy drop start", 32'(core_start), 1);

        // Reset during WAIT with two jobs queued.
        do_reset();
        nxt(); r0_valid = 1; r0_row = 3'd2;
        nxt(); r0_valid = 0; r1_valid = 1; r1_row = 3'd4;
        nxt(); r1_valid = 0; r0_valid = 1; r0_row = 3'd7;
        nxt(); r0_valid = 0;
        nxt();
        nxt();
        #1 chk("pre-reset q_count", 32'(q_count), 2);
        chk("pre-reset busy", 32'(sched_busy), 1);
        rst = 1;
        #1 chk("rst q_count", 32'(q_count), 0);
        chk("rst busy", 32'(sched_busy), 0);
        chk("rst row_idx", 32'(core_row_idx), 0);
        chk("rst start", 32'(core_start), 0);
        nxt(); nxt(); rst = 0;
        rsp_seen = 0;
        for (int i = 0; i < 40; i++) begin
            nxt(); core_done = 1'(i % 3 == 0);
            #1 rsp_seen += int'(rsp_valid);
        end
        core_done = 0;
        chk("no rsp after reset", 32'(rsp_seen), 0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst       = $urandom_range(0, 299) == 0;
            r0_valid  = $urandom_range(0, 2) == 0;
            r1_valid  = $urandom_range(0, 2) == 0;
            r0_mode   = 1'($urandom);
            r1_mode   = 1'($urandom);
            r0_row    = 3'($urandom);
            r1_row    = 3'($urandom);
            r0_col    = 3'($urandom);
            r1_col    = 3'($urandom);
            r0_len    = 8'($urandom);
            r1_len    = 8'($urandom);
            core_busy = $urandom_range(0, 3) == 0;
            core_done = $urandom_range(0, 5) == 0;
        end
        rst = 0;
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
